// File: rtl/pn_ctrl_pkg.sv
// Shared types and constants for the PN burst controller: FSM states and the
// 4-bit x^4+x^3+1 LFSR geometry.
package pn_ctrl_pkg;

  localparam int LFSR_W = 4;
  localparam int TAP_HI = 3;
  localparam int TAP_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Right-shifting Fibonacci step; feedback enters at the MSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[TAP_LO] ^ s[TAP_HI], s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/pn_lfsr4.sv
// 4-bit PN generator register: parallel load has priority over stepping.
module pn_lfsr4
  import pn_ctrl_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              load,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load)    state_d = seed;
    else if (en) state_d = lfsr_next(state_q);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= '0;
    else            state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/pn_burst_ctrl.sv
// PN chip burst controller with valid/ready output handshake.
// Optional zero-seed rejection is built when PN_SEED_CHECK_EN is defined.
module pn_burst_ctrl
  import pn_ctrl_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [3:0]       seed,
  input  logic [LEN_W-1:0] chip_cnt,
  input  logic             stop,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_bit,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             period_tick,
  output logic             err_seed
);

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] seed_q, seed_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LFSR_W-1:0] lfsr_state;
  logic              lfsr_load;
  logic              run, xfer, last_hit, seed_bad;

  assign run      = (state_q == ST_RUN);
  assign xfer     = run && out_ready;
  // A zero length means continuous, so it never produces a final chip.
  assign last_hit = run && (len_q != '0) && (cnt_q == len_q - LEN_W'(1));

`ifdef PN_SEED_CHECK_EN
  logic err_q, err_d;
  assign seed_bad = (seed == '0);
  assign err_d    = (state_q == ST_IDLE) && start && seed_bad;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) err_q <= 1'b0;
    else            err_q <= err_d;
  end

  assign err_seed = err_q;
`else
  assign seed_bad = 1'b0;
  assign err_seed = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    lfsr_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !seed_bad) begin
          seed_d  = seed;
          len_d   = chip_cnt;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        lfsr_load = 1'b1;
        cnt_d     = '0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (xfer) cnt_d = cnt_q + LEN_W'(1);
        // Stop together with the final transfer is just a normal end.
        if ((xfer && last_hit) || stop) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      seed_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  pn_lfsr4 u_lfsr (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (lfsr_load),
    .en        (xfer),
    .seed      (seed_q),
    .state     (lfsr_state)
  );

  assign out_valid   = run;
  assign out_bit     = run && lfsr_state[0];
  assign out_last    = last_hit;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign period_tick = xfer && (lfsr_next(lfsr_state) == seed_q);

endmodule

// File: tb/tb_pn_burst_ctrl.sv
// Bench for pn_burst_ctrl: table of bursts driven through a chip scoreboard,
// plus hand sequences for zero seed and reset mid-burst.
module tb_pn_burst_ctrl;

  localparam int LEN_W = 16;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             start = 1'b0;
  logic [3:0]       seed = 4'h0;
  logic [LEN_W-1:0] chip_cnt = '0;
  logic             stop = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid, out_bit, out_last, busy, done, period_tick, err_seed;

  pn_burst_ctrl #(.LEN_W(LEN_W)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .start       (start),
    .seed        (seed),
    .chip_cnt    (chip_cnt),
    .stop        (stop),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_bit     (out_bit),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .period_tick (period_tick),
    .err_seed    (err_seed)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic b;
    logic last;
    logic tick;
  } exp_t;

  // mode: 0 ready always, 1 ready toggles 1,0,..., 2 random ready (+ stray starts)
  typedef struct {
    logic [3:0]       seed;
    logic [LEN_W-1:0] len;
    int               mode;
    int               stop_at;
    int               exp_chips;
    int               exp_last;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          last_cnt = 0;
  logic [14:0] rec = '0;

  localparam logic [14:0] SEQ_0110 = 15'b011001000111101;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] mstep(input logic [3:0] s);
    return {s[0] ^ s[3], s[3:1]};
  endfunction

  task automatic push_exp(input logic [3:0] sd, input logic [LEN_W-1:0] len, input int cnt);
    logic [3:0] s;
    s = sd;
    for (int k = 1; k <= cnt; k++) begin
      exp_t e;
      e.b    = s[0];
      s      = mstep(s);
      e.tick = (s == sd);
      e.last = (len != '0) && (32'(len) == k);
      sb.push_back(e);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   n, d0, l0;
    logic r, xv, ok;
    push_exp(v.seed, v.len, v.exp_chips);
    d0 = done_cnt;
    l0 = last_cnt;
    @(posedge sys_clk); #1;
    start = 1'b1; seed = v.seed; chip_cnt = v.len;
    @(posedge sys_clk); #1;
    start = 1'b0; seed = 4'($urandom); chip_cnt = 16'($urandom);
    chk({tag, " load_busy"}, 32'(busy), 32'd1);
    chk({tag, " load_valid"}, 32'(out_valid), 32'd0);
    @(posedge sys_clk); #1;
    n = 0;
    ok = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      stop  = 1'b0;
      start = 1'b0;
      if (done) begin
        ok = 1'b1;
        break;
      end
      case (v.mode)
        1:       r = (cyc % 2 == 0);
        2:       r = 1'($urandom_range(0, 1));
        default: r = 1'b1;
      endcase
      out_ready = r;
      if (v.mode == 2) begin
        start = 1'($urandom_range(0, 1));
        seed  = 4'($urandom);
      end
      if (v.stop_at > 0 && r && n == v.stop_at - 1) stop = 1'b1;
      xv = r && out_valid;
      @(posedge sys_clk); #1;
      if (xv) n++;
    end
    chk({tag, " done_seen"}, 32'(ok), 32'd1);
    chk({tag, " done_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " chips"}, 32'(n), 32'(v.exp_chips));
    // a start while in DONE must not launch a new burst
    start = 1'b1; seed = 4'h5; chip_cnt = 16'd2; out_ready = 1'b0;
    @(posedge sys_clk); #1;
    start = 1'b0;
    chk({tag, " idle_after_done"}, 32'(busy), 32'd0);
    chk({tag, " done_width"}, 32'(done), 32'd0);
    chk({tag, " done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, " last_count"}, 32'(last_cnt - l0), 32'(v.exp_last));
    chk({tag, " sb_empty"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    fork
      begin : monitor
        exp_t       e;
        logic       held_v;
        logic [1:0] held;
        held_v = 1'b0;
        held   = '0;
        forever begin
          @(negedge sys_clk);
          if (done) done_cnt++;
          if (out_valid && held_v) chk("stall_hold", 32'({out_bit, out_last}), 32'(held));
          held_v = out_valid && !out_ready;
          held   = {out_bit, out_last};
          if (out_valid && out_ready) begin
            rec = {rec[13:0], out_bit};
            if (out_last) last_cnt++;
            if (sb.size() == 0) chk("extra_chip", 32'd1, 32'd0);
            else begin
              e = sb.pop_front();
              chk("chip_bit", 32'(out_bit), 32'(e.b));
              chk("chip_last", 32'(out_last), 32'(e.last));
              chk("period_tick", 32'(period_tick), 32'(e.tick));
            end
          end else if (busy) chk("tick_no_xfer", 32'(period_tick), 32'd0);
        end
      end
    join_none

    #2;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_bit", 32'(out_bit), 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst period_tick", 32'(period_tick), 32'd0);
    chk("rst err_seed", 32'(err_seed), 32'd0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    vecs.push_back('{4'b0110, 16'd15, 0, 0, 15, 1});
    vecs.push_back('{4'b1000, 16'd4, 1, 0, 4, 1});
    vecs.push_back('{4'b1001, 16'd0, 0, 20, 20, 0});
    vecs.push_back('{4'b0101, 16'd3, 0, 3, 3, 1});
    vecs.push_back('{4'b1111, 16'd7, 2, 0, 7, 1});
    vecs.push_back('{4'b0011, 16'd5, 0, 2, 2, 0});
    vecs.push_back('{4'b0001, 16'd1, 0, 0, 1, 1});
    vecs.push_back('{4'b1010, 16'd0, 2, 32, 32, 0});

    foreach (vecs[i]) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
      if (i == 0) chk("seq_0110", 32'(rec), 32'(SEQ_0110));
    end

`ifdef PN_SEED_CHECK_EN
    @(posedge sys_clk); #1;
    start = 1'b1; seed = 4'h0; chip_cnt = 16'd5;
    @(posedge sys_clk); #1;
    start = 1'b0;
    chk("zero_seed err", 32'(err_seed), 32'd1);
    chk("zero_seed busy", 32'(busy), 32'd0);
    @(posedge sys_clk); #1;
    chk("zero_seed err_width", 32'(err_seed), 32'd0);
    chk("zero_seed busy2", 32'(busy), 32'd0);
`else
    begin
      vec_t z;
      z = '{4'b0000, 16'd5, 0, 0, 5, 1};
      run_vec(z, "zero_seed");
      chk("zero_seed chips", 32'(rec[4:0]), 32'd0);
      chk("zero_seed err", 32'(err_seed), 32'd0);
    end
`endif

    begin
      int d0;
      push_exp(4'b0110, 16'd15, 15);
      @(posedge sys_clk); #1;
      start = 1'b1; seed = 4'b0110; chip_cnt = 16'd15; out_ready = 1'b1;
      @(posedge sys_clk); #1;
      start = 1'b0;
      repeat (5) @(posedge sys_clk);
      #3 sys_rst_n = 1'b0;
      #1;
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst out_bit", 32'(out_bit), 32'd0);
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      sb.delete();
      d0 = done_cnt;
      repeat (3) @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      out_ready = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      chk("midrst no_done", 32'(done_cnt - d0), 32'd0);
      chk("midrst idle", 32'(busy), 32'd0);
      run_vec(vecs[0], "after_rst");
      chk("after_rst seq_0110", 32'(rec), 32'(SEQ_0110));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pn_burst_ctrl.md
PN_BURST_CTRL -- requirements
Module: pn_burst_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 16, meaning width of the burst-length field and the chip counter.
REQ-002 SHALL have port sys_clk, input, 1, the single clock; all flops on its rising edge.
REQ-003 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, burst request; sampled only in IDLE.
REQ-005 SHALL have port seed, input, 4, LFSR initial state; latched on accepted start.
REQ-006 SHALL have port chip_cnt, input, LEN_W, burst length in chips; 0 = continuous; latched on accepted start.
REQ-007 SHALL have port stop, input, 1, abort request; honoured in RUN only.
REQ-008 SHALL have port out_ready, input, 1, downstream ready.
REQ-009 SHALL have ports out_valid/out_bit/out_last, output, 1 each: chip valid, chip value, final chip of burst.
REQ-010 SHALL have ports busy (output, 1, state != IDLE), done (output, 1, one-cycle burst-end pulse), period_tick (output, 1, LFSR back at latched seed), err_seed (output, 1, zero-seed reject pulse).

Function
REQ-011 SHALL implement FSM IDLE -> LOAD -> RUN -> DONE -> IDLE.
REQ-012 IDLE: start=1 SHALL latch seed and chip_cnt and move to LOAD next cycle; start outside IDLE SHALL be ignored.
REQ-013 LOAD: SHALL load latched seed into LFSR, clear chip counter, move to RUN; outputs out_valid=0.
REQ-014 RUN: out_valid SHALL be 1; out_bit SHALL equal LFSR bit 0.
REQ-015 LFSR SHALL be 4-bit, x^4+x^3+1: next = {s[0]^s[3], s[3:1]}; period 15 for any nonzero seed.
REQ-016 A chip SHALL transfer when out_valid and out_ready are both 1; only then do LFSR and counter advance.
REQ-017 While out_valid=1 and out_ready=0, out_bit and out_last SHALL hold stable.
REQ-018 out_last SHALL be 1 in RUN when counter == chip_cnt-1 (chip_cnt != 0); its transfer SHALL move FSM to DONE.
REQ-019 chip_cnt=0 SHALL run until stop; counter wraps modulo 2^LEN_W with no other effect; out_last stays 0.
REQ-020 stop in RUN SHALL move FSM to DONE next cycle; a chip transferring in the same cycle counts as delivered; out_last is not asserted for an aborted burst.
REQ-021 stop and final-chip transfer in the same cycle SHALL behave as a normal end (single DONE).
REQ-022 DONE: done=1 for exactly one cycle, out_valid=0, then IDLE; start in DONE is ignored.
REQ-023 period_tick SHALL pulse for one cycle when a transfer makes the LFSR state equal the latched seed (every 15th transfer).

Reset
REQ-024 sys_rst_n=0 SHALL asynchronously force IDLE, LFSR=4'b0000, counter=0, latched registers=0, all outputs 0.
REQ-025 Reset mid-burst SHALL abandon the burst without a done pulse; first start after release proceeds normally.

Configuration
REQ-026 With PN_SEED_CHECK_EN defined, start with seed=0 SHALL stay in IDLE and pulse err_seed for one cycle.
REQ-027 Without PN_SEED_CHECK_EN, err_seed SHALL be tied 0 and a zero seed SHALL run normally, producing all-zero chips.

Structure
REQ-028 Package pn_ctrl_pkg SHALL hold the FSM state enum, LFSR width constant (4) and tap constants.
REQ-029 LFSR SHALL be sub-module pn_lfsr4 (inputs load, en, seed; output state), async active-low reset.

Verification
REQ-030 seed=4'b0110, chip_cnt=15, out_ready=1 -> busy, 1 LOAD cycle, 15 chips 0,1,1,0,0,1,0,0,0,1,1,1,1,0,1; out_last on 15th; period_tick with 15th; done next cycle.
REQ-031 seed=4'b1000, chip_cnt=4, out_ready toggling 1,0,1,0 -> chips 0,0,0,1 delivered, out_bit stable across each stall, out_last only on 4th.
REQ-032 chip_cnt=0, stop after 20 transfers -> 20 chips, period_tick after 15th, no out_last, done one cycle after stop.
REQ-033 stop coincident with 3rd chip of chip_cnt=3 burst -> 3 chips, out_last on 3rd, exactly one done pulse.
REQ-034 seed=0 with PN_SEED_CHECK_EN -> err_seed one-cycle pulse, busy stays 0; without macro -> burst runs, all chips 0.
REQ-035 sys_rst_n low mid-RUN -> outputs 0 immediately, no done; next start with seed=4'b0110 reproduces REQ-030 sequence.
